// File: rtl/gpr_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_sequencer
// Description : Round-robin commit arbiter that serialises full-warp results
//               into per-slice GPR write beats plus a scoreboard release pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_sequencer #(
    parameter int NUM_INPUTS    = 2,
    parameter int SIMD_COUNT    = 2,
    parameter int SIMD_WIDTH    = 4,
    parameter int XLEN          = 32,
    parameter int WIS_W         = 2,
    parameter int NUM_REGS_BITS = 6
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_INPUTS-1:0]                           in_valid,
    output logic [NUM_INPUTS-1:0]                           in_ready,
    input  logic [NUM_INPUTS*WIS_W-1:0]                     in_wis,
    input  logic [NUM_INPUTS*NUM_REGS_BITS-1:0]             in_rd,
    input  logic [NUM_INPUTS-1:0]                           in_wb,
    input  logic [NUM_INPUTS*SIMD_COUNT*SIMD_WIDTH-1:0]      in_tmask,
    input  logic [NUM_INPUTS*SIMD_COUNT*SIMD_WIDTH*XLEN-1:0] in_data,
    output logic                                            wb_valid,
    output logic [WIS_W-1:0]                                wb_wis,
    output logic [((SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1)-1:0] wb_sid,
    output logic [NUM_REGS_BITS-1:0]                        wb_rd,
    output logic [SIMD_WIDTH-1:0]                           wb_tmask,
    output logic [SIMD_WIDTH*XLEN-1:0]                      wb_data,
    output logic                                            wb_sop,
    output logic                                            wb_eop,
    output logic                                            rel_valid,
    output logic [WIS_W-1:0]                                rel_wis,
    output logic [NUM_REGS_BITS-1:0]                        rel_rd
);

    localparam int c_SID_W      = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
    localparam int c_IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int c_LANES      = SIMD_COUNT * SIMD_WIDTH;
    localparam int c_SLICE_BITS = SIMD_WIDTH * XLEN;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_IDX_W-1:0]            r_rr_ptr;
    logic [WIS_W-1:0]              r_wis;
    logic [NUM_REGS_BITS-1:0]      r_rd;
    logic [c_LANES-1:0]            r_tmask;
    logic [c_LANES*XLEN-1:0]       r_data;
    logic [c_SID_W-1:0]            r_sid;
    logic                          r_sop;

    logic                          w_grant_found;
    logic [c_IDX_W-1:0]            w_grant_idx;
    logic [WIS_W-1:0]              w_sel_wis;
    logic [NUM_REGS_BITS-1:0]      w_sel_rd;
    logic                          w_sel_wb;
    logic [c_LANES-1:0]            w_sel_tmask;
    logic [c_LANES*XLEN-1:0]       w_sel_data;
    logic                          w_is_write;
    logic                          w_next_found;
    logic [c_SID_W-1:0]            w_next_sid;
    logic [c_SID_W-1:0]            w_first_sid;
    logic                          w_last_beat;
    logic                          w_accept;

    // First valid source at or after the round-robin pointer wins.
    always_comb begin : arb_search
        int idx;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_INPUTS;
            if (!w_grant_found && in_valid[idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = c_IDX_W'(idx);
            end
        end
    end

    assign w_sel_wis   = in_wis[w_grant_idx*WIS_W +: WIS_W];
    assign w_sel_rd    = in_rd[w_grant_idx*NUM_REGS_BITS +: NUM_REGS_BITS];
    assign w_sel_wb    = in_wb[w_grant_idx];
    assign w_sel_tmask = in_tmask[w_grant_idx*c_LANES +: c_LANES];
    assign w_sel_data  = in_data[w_grant_idx*c_LANES*XLEN +: c_LANES*XLEN];
    assign w_is_write  = w_sel_wb && (w_sel_rd != '0) && (|w_sel_tmask);

    // Descending scan leaves the lowest qualifying slice index.
    always_comb begin
        w_next_found = 1'b0;
        w_next_sid   = '0;
        w_first_sid  = '0;
        for (int s = SIMD_COUNT - 1; s >= 0; s--) begin
            if ((s > int'(r_sid)) && (|r_tmask[s*SIMD_WIDTH +: SIMD_WIDTH])) begin
                w_next_found = 1'b1;
                w_next_sid   = c_SID_W'(s);
            end
            if (|w_sel_tmask[s*SIMD_WIDTH +: SIMD_WIDTH]) begin
                w_first_sid = c_SID_W'(s);
            end
        end
    end

    assign w_last_beat = (r_state == ISSUE) && !w_next_found;
    assign w_accept    = !reset && w_grant_found && ((r_state == IDLE) || w_last_beat);

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_ready[i] = w_accept && (w_grant_idx == c_IDX_W'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_write) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (w_last_beat) w_state_nxt = (w_accept && w_is_write) ? ISSUE : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_wis    <= '0;
            r_rd     <= '0;
            r_tmask  <= '0;
            r_data   <= '0;
            r_sid    <= '0;
            r_sop    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rr_ptr <= (int'(w_grant_idx) == NUM_INPUTS - 1) ? '0 : w_grant_idx + 1'b1;
            end
            if (w_accept && w_is_write) begin
                r_wis   <= w_sel_wis;
                r_rd    <= w_sel_rd;
                r_tmask <= w_sel_tmask;
                r_data  <= w_sel_data;
                r_sid   <= w_first_sid;
                r_sop   <= 1'b1;
            end else if ((r_state == ISSUE) && !w_last_beat) begin
                r_sid <= w_next_sid;
                r_sop <= 1'b0;
            end
        end
    end

    // Outputs are forced low during reset so a held commit never leaks a beat.
    assign wb_valid  = (r_state == ISSUE) && !reset;
    assign wb_wis    = reset ? '0 : r_wis;
    assign wb_rd     = reset ? '0 : r_rd;
    assign wb_sid    = reset ? '0 : r_sid;
    assign wb_tmask  = reset ? '0 : r_tmask[r_sid*SIMD_WIDTH +: SIMD_WIDTH];
    assign wb_data   = reset ? '0 : r_data[r_sid*c_SLICE_BITS +: c_SLICE_BITS];
    assign wb_sop    = wb_valid && r_sop;
    assign wb_eop    = wb_valid && w_last_beat;
    assign rel_valid = wb_eop;
    assign rel_wis   = wb_wis;
    assign rel_rd    = wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_wb_sequencer
// Description : Directed self-checking bench with a queue-based beat model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_sequencer;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   in_valid = '0;
    logic [1:0]   in_ready;
    logic [3:0]   in_wis = '0;
    logic [11:0]  in_rd = '0;
    logic [1:0]   in_wb = '0;
    logic [15:0]  in_tmask = '0;
    logic [511:0] in_data = '0;
    logic         wb_valid;
    logic [1:0]   wb_wis;
    logic [0:0]   wb_sid;
    logic [5:0]   wb_rd;
    logic [3:0]   wb_tmask;
    logic [127:0] wb_data;
    logic         wb_sop, wb_eop, rel_valid;
    logic [1:0]   rel_wis;
    logic [5:0]   rel_rd;

    int checks = 0;
    int errors = 0;

    gpr_wb_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wis(in_wis), .in_rd(in_rd), .in_wb(in_wb),
        .in_tmask(in_tmask), .in_data(in_data),
        .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_sid(wb_sid), .wb_rd(wb_rd),
        .wb_tmask(wb_tmask), .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop),
        .rel_valid(rel_valid), .rel_wis(rel_wis), .rel_rd(rel_rd)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]   wis;
        logic         sid;
        logic [5:0]   rd;
        logic [3:0]   tm;
        logic [127:0] data;
        logic         sop;
        logic         eop;
    } beat_t;

    beat_t q[$];
    int    rr = 0;

    // Expand an accepted commit into its expected beats.
    task automatic push_commit(int g);
        logic [7:0] tm;
        logic [5:0] rd;
        beat_t      tmp[2];
        int         n;
        tm = in_tmask[g*8 +: 8];
        rd = in_rd[g*6 +: 6];
        n  = 0;
        if (in_wb[g] && rd != 6'd0 && tm != 8'd0) begin
            for (int s = 0; s < 2; s++) begin
                if (tm[s*4 +: 4] != 4'd0) begin
                    tmp[n].wis  = in_wis[g*2 +: 2];
                    tmp[n].sid  = 1'(s);
                    tmp[n].rd   = rd;
                    tmp[n].tm   = tm[s*4 +: 4];
                    tmp[n].data = in_data[g*256 + s*128 +: 128];
                    n++;
                end
            end
            for (int j = 0; j < n; j++) begin
                tmp[j].sop = (j == 0);
                tmp[j].eop = (j == n - 1);
                q.push_back(tmp[j]);
            end
        end
    endtask

    always @(negedge clk) begin
        int         g;
        logic [1:0] exp_ready;
        beat_t      b;
        if (reset) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_wb_valid", wb_valid, 0);
            check("rst_rel_valid", rel_valid, 0);
            check("rst_sop_eop", {wb_sop, wb_eop}, 0);
            check("rst_wb_data", wb_data, 0);
            check("rst_fields", {wb_wis, wb_sid, wb_rd, wb_tmask, rel_wis, rel_rd}, 0);
            q.delete();
            rr = 0;
        end else begin
            g = -1;
            exp_ready = '0;
            if (q.size() <= 1) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (rr + k) % N;
                    if (g < 0 && in_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("in_ready", in_ready, exp_ready);
            check("wb_valid", wb_valid, q.size() > 0);
            if (q.size() > 0) begin
                b = q[0];
                check("wb_wis", wb_wis, b.wis);
                check("wb_sid", wb_sid, b.sid);
                check("wb_rd", wb_rd, b.rd);
                check("wb_tmask", wb_tmask, b.tm);
                check("wb_data", wb_data, b.data);
                check("wb_sop", wb_sop, b.sop);
                check("wb_eop", wb_eop, b.eop);
                check("rel_valid", rel_valid, b.eop);
                if (b.eop) check("rel_target", {rel_wis, rel_rd}, {b.wis, b.rd});
                void'(q.pop_front());
            end else begin
                check("idle_rel_valid", rel_valid, 0);
                check("idle_sop_eop", {wb_sop, wb_eop}, 0);
            end
            if (g >= 0) begin
                rr = (g + 1) % N;
                push_commit(g);
            end
        end
    end

    task automatic drive_src(int i, logic [1:0] wis, logic [5:0] rd, logic wb, logic [7:0] tm);
        in_valid[i]          = 1'b1;
        in_wis[i*2 +: 2]     = wis;
        in_rd[i*6 +: 6]      = rd;
        in_wb[i]             = wb;
        in_tmask[i*8 +: 8]   = tm;
        for (int l = 0; l < 8; l++) begin
            in_data[i*256 + l*32 +: 32] = {8'hC0 + 8'(i), 2'b00, rd, 16'h1000 + 16'(l)};
        end
    endtask

    task automatic run_one(int i, logic [1:0] wis, logic [5:0] rd, logic wb, logic [7:0] tm,
                           logic [1:0] exp_ready, string tag);
        drive_src(i, wis, rd, wb, tm);
        @(negedge clk);
        check({tag, "_ready"}, in_ready, exp_ready);
        @(posedge clk); #1;
        in_valid = '0;
    endtask

    initial begin
        int grants[$];
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lit_rst_valid", {wb_valid, rel_valid, in_ready}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Two-slice commit: sid0 sop, then sid1 eop with release.
        run_one(0, 2'd1, 6'd5, 1'b1, 8'hFF, 2'b01, "t1");
        @(negedge clk);
        check("t1_b0_ctl", {wb_valid, wb_sid, wb_sop, wb_eop, rel_valid}, 5'b10100);
        check("t1_b0_wis", wb_wis, 2'd1);
        check("t1_b0_data", wb_data, 128'hC0051003_C0051002_C0051001_C0051000);
        @(negedge clk);
        check("t1_b1_ctl", {wb_valid, wb_sid, wb_sop, wb_eop, rel_valid}, 5'b11011);
        check("t1_rel_rd", rel_rd, 6'd5);
        check("t1_b1_tmask", wb_tmask, 4'hF);
        @(negedge clk);
        check("t1_done", wb_valid, 1'b0);
        @(posedge clk); #1;

        // Upper slice only: a single beat on sid1.
        run_one(1, 2'd2, 6'd7, 1'b1, 8'hF0, 2'b10, "t2");
        @(negedge clk);
        check("t2_ctl", {wb_valid, wb_sid, wb_sop, wb_eop, rel_valid}, 5'b11111);
        check("t2_tmask", wb_tmask, 4'hF);
        check("t2_rel", {rel_wis, rel_rd}, {2'd2, 6'd7});
        check("t2_data", wb_data, 128'hC1071007_C1071006_C1071005_C1071004);
        @(negedge clk);
        check("t2_done", wb_valid, 1'b0);
        @(posedge clk); #1;

        // Sparse lane mask in both slices.
        run_one(0, 2'd3, 6'd9, 1'b1, 8'h5A, 2'b01, "t3");
        @(negedge clk);
        check("t3_b0_tmask", wb_tmask, 4'hA);
        @(negedge clk);
        check("t3_b1_tmask", wb_tmask, 4'h5);
        @(negedge clk);
        @(posedge clk); #1;

        // Non-writing commits are consumed in one cycle with no beat.
        run_one(1, 2'd0, 6'd0, 1'b1, 8'hFF, 2'b10, "skip_rd0");
        @(negedge clk);
        check("skip_rd0_none", {wb_valid, rel_valid}, 2'b00);
        @(posedge clk); #1;
        run_one(0, 2'd1, 6'd12, 1'b0, 8'hFF, 2'b01, "skip_wb0");
        @(negedge clk);
        check("skip_wb0_none", {wb_valid, rel_valid}, 2'b00);
        @(posedge clk); #1;
        run_one(1, 2'd1, 6'd13, 1'b1, 8'h00, 2'b10, "skip_tm0");
        @(negedge clk);
        check("skip_tm0_none", {wb_valid, rel_valid}, 2'b00);
        @(posedge clk); #1;

        // Both sources streaming two-slice commits: alternating grants, no bubbles.
        drive_src(0, 2'd0, 6'd10, 1'b1, 8'hFF);
        drive_src(1, 2'd3, 6'd11, 1'b1, 8'h3C);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_ready != 2'b00) grants.push_back(in_ready[1] ? 1 : 0);
            if (c >= 1) check("t4_no_bubble", wb_valid, 1'b1);
        end
        check("t4_grant_count", grants.size(), 5);
        for (int j = 0; j < 4 && j < grants.size(); j++) begin
            check("t4_grant_order", grants[j], j % 2);
        end
        @(posedge clk); #1;
        in_valid = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;

        // Reset during the eop cycle drops the commit and rewinds arbitration.
        run_one(0, 2'd1, 6'd20, 1'b1, 8'hFF, 2'b01, "t5");
        @(negedge clk);
        check("t5_sop", {wb_valid, wb_sop, wb_sid}, 3'b110);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_out", {wb_valid, wb_eop, rel_valid, in_ready}, 0);
        check("t5_rst_data", wb_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_eop", {wb_valid, rel_valid}, 2'b00);
        @(posedge clk); #1;
        drive_src(0, 2'd0, 6'd21, 1'b1, 8'hFF);
        drive_src(1, 2'd1, 6'd22, 1'b1, 8'hFF);
        @(negedge clk);
        check("t5_rr_restart", in_ready, 2'b01);
        @(posedge clk); #1;
        in_valid = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
